// File: rtl/wfg_timer.sv
// wfg_timer: Wishbone-slave prescaled timer with compare match, one-shot/periodic modes and level interrupt
module wfg_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        interrupt_o
);
  logic        en, periodic, irq_en, pending;
  logic [31:0] compare, counter, rdata;
  logic [15:0] prescaler, pre_cnt;
  logic [5:0]  ofs;
  logic        acc, wr, tick, hit;
  logic        unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};
  assign ofs = wbs_adr_i[7:2];
  // a transfer is taken only on the cycle that will raise ack, so a held strobe yields every other cycle
  assign acc = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr = acc & wbs_we_i;
  assign tick = en & (pre_cnt == prescaler);
  assign hit = tick & (counter == compare);
  assign interrupt_o = pending & irq_en;
  always_comb
    rdata = ofs == 6'd0 ? {29'd0, irq_en, periodic, en} :
            ofs == 6'd1 ? compare :
            ofs == 6'd2 ? counter :
            ofs == 6'd3 ? {31'd0, pending} :
            ofs == 6'd4 ? {16'd0, prescaler} : 32'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      {irq_en, periodic, en} <= '0;
      pending <= 1'b0;
      compare <= '0;
      counter <= '0;
      prescaler <= '0;
      pre_cnt <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : '0;
      if (wr && ofs == 6'd0) {irq_en, periodic, en} <= wbs_dat_i[2:0];
      else if (hit && !periodic) en <= 1'b0;
      if (wr && ofs == 6'd1) compare <= wbs_dat_i;
      if (wr && ofs == 6'd2) begin
        counter <= wbs_dat_i;
        pre_cnt <= '0;
      end else if (en) begin
        pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
        if (tick) counter <= hit ? (periodic ? 32'd0 : counter) : counter + 32'd1;
      end
      if (hit) pending <= 1'b1;
      else if (wr && ofs == 6'd3 && wbs_dat_i[0]) pending <= 1'b0;
      if (wr && ofs == 6'd4) prescaler <= wbs_dat_i[15:0];
    end
endmodule

// File: tb/tb_wfg_timer.sv
// tb_wfg_timer: directed self-checking bench for wfg_timer
module tb_wfg_timer;
  logic        clk, rst, stb, cyc, we, ack, irq;
  logic [31:0] dat_i, adr, dat_o;
  int tests = 0;
  int fails = 0;

  localparam logic [31:0] CTRL = 32'h00, CMP = 32'h04, CNT = 32'h08, STAT = 32'h0C, PRE = 32'h10;

  wfg_timer dut (
    .clk(clk), .rst(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .interrupt_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called #1 after an edge; returns #1 after the ack edge
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
    int n;
    if (ack) begin @(posedge clk); #1; end
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 4);
    chk("ack_latency", 32'(n), 32'd1);
    r = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x;
    wb(1'b1, a, d, x);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] x;
    wb(1'b0, a, 32'd0, x);
    chk(tag, x, exp);
  endtask

  initial begin
    logic [31:0] offs [6];
    int pulses;
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20};
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; dat_i = '0; adr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    foreach (offs[i]) rd_chk("reset_read", offs[i], 32'd0);
    @(posedge clk); #1;
    chk("ack_one_cycle", ack, 0);

    // periodic: compare 4, prescaler 0
    wr(CMP, 32'd4);
    wr(PRE, 32'd0);
    wr(CTRL, 32'h7);
    repeat (4) @(posedge clk);
    #1;
    chk("per_irq_before", irq, 0);
    @(posedge clk); #1;
    chk("per_irq_match", irq, 1);
    wr(STAT, 32'd1);
    chk("per_w1c", irq, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("per_irq_before2", irq, 0);
    @(posedge clk); #1;
    chk("per_irq_match2", irq, 1);
    wr(CTRL, 32'h0);
    wr(STAT, 32'd1);
    chk("per_cleared", irq, 0);

    // one-shot: compare 2, prescaler 3
    wr(CMP, 32'd2);
    wr(PRE, 32'd3);
    wr(CNT, 32'd0);
    wr(CTRL, 32'h5);
    repeat (11) @(posedge clk);
    #1;
    chk("os_irq_before", irq, 0);
    @(posedge clk); #1;
    chk("os_irq_match", irq, 1);
    rd_chk("os_ctrl", CTRL, 32'h4);
    rd_chk("os_counter", CNT, 32'd2);
    repeat (8) @(posedge clk);
    #1;
    rd_chk("os_counter_hold", CNT, 32'd2);
    chk("os_irq_level", irq, 1);
    wr(STAT, 32'd1);
    chk("os_cleared", irq, 0);

    // wrap past 0xFFFFFFFF
    wr(PRE, 32'd0);
    wr(CMP, 32'd1);
    wr(CNT, 32'hFFFF_FFFE);
    wr(CTRL, 32'h3);
    rd_chk("wrap_ffffffff", CNT, 32'hFFFF_FFFF);
    rd_chk("wrap_one", CNT, 32'd1);
    rd_chk("wrap_pending", STAT, 32'd1);
    chk("wrap_irq_masked", irq, 0);
    wr(CTRL, 32'h0);
    wr(STAT, 32'd1);
    rd_chk("wrap_cleared", STAT, 32'd0);

    // W1C on the match edge loses to the set
    wr(CMP, 32'd4);
    wr(CNT, 32'd0);
    wr(CTRL, 32'h7);
    repeat (4) @(posedge clk);
    #1;
    chk("sim_irq_before", irq, 0);
    wr(STAT, 32'd1);
    chk("sim_set_wins", irq, 1);
    // counter write on a tick edge wins, then two more ticks
    wr(CNT, 32'h100);
    wr(CTRL, 32'h0);
    rd_chk("sim_write_wins", CNT, 32'h102);
    wr(STAT, 32'd1);
    chk("sim_cleared", irq, 0);

    // held strobe
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h20; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("held_ack", ack, (i % 2 == 0) ? 32'd1 : 32'd0);
      pulses += int'(ack);
    end
    chk("held_pulses", 32'(pulses), 32'd3);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset mid-operation
    wr(CNT, 32'd0);
    wr(CTRL, 32'h7);
    repeat (6) @(posedge clk);
    #1;
    chk("ar_irq_pre", irq, 1);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = CMP;
    @(posedge clk); #1;
    chk("ar_ack_pre", ack, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_ack", ack, 0);
    chk("ar_dat", dat_o, 0);
    chk("ar_irq", irq, 0);
    stb = 1'b0; cyc = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("ar_ctrl", CTRL, 32'h0);
    rd_chk("ar_compare", CMP, 32'h0);
    rd_chk("ar_counter", CNT, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
